// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - multi-cycle instruction-memory responder
// Single outstanding read/write with fixed latency and Stall/Done handshake.
module imem_responder #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Rd,
   input  logic              Wr,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] DataIn,
   output logic [DATA_W-1:0] DataOut,
   output logic              Done,
   output logic              Stall,
   output logic              Err
);

   localparam int         DEPTH   = 1 << DEPTH_LOG2;
   localparam logic       ST_IDLE = 1'b0;
   localparam logic       ST_BUSY = 1'b1;
   localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);

   logic                  state;
   logic [3:0]            cnt;
   logic                  lat_wr;
   logic [DEPTH_LOG2-1:0] lat_idx;
   logic [DATA_W-1:0]     lat_data;

   logic [DATA_W-1:0]     mem [DEPTH];

   logic                  req_ok;
   logic                  req_bad;
   logic                  fin;
   logic                  fin_wr;
   logic [DEPTH_LOG2-1:0] fin_idx;
   logic [DATA_W-1:0]     fin_data;
   logic                  unused_addr_hi;

   // High address bits are dropped on purpose so the array aliases.
   assign unused_addr_hi = ^Addr[ADDR_W-1:DEPTH_LOG2+1];

   assign req_ok  = (state == ST_IDLE) && (Rd ^ Wr) && !Addr[0];
   assign req_bad = (state == ST_IDLE) && (Rd | Wr) && !req_ok;

   // With a latency of one the request completes at its own acceptance edge.
   always_comb begin
      fin      = 1'b0;
      fin_wr   = lat_wr;
      fin_idx  = lat_idx;
      fin_data = lat_data;
      if (LATENCY == 1) begin
         fin      = req_ok;
         fin_wr   = Wr;
         fin_idx  = Addr[DEPTH_LOG2:1];
         fin_data = DataIn;
      end else begin
         fin      = (state == ST_BUSY) && (cnt == 4'd1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= 4'd0;
         lat_wr   <= 1'b0;
         lat_idx  <= '0;
         lat_data <= '0;
         DataOut  <= '0;
         Done     <= 1'b0;
         Stall    <= 1'b0;
         Err      <= 1'b0;
      end else begin
         Done <= fin;
         Err  <= req_bad;
         if (fin && !fin_wr) begin
            DataOut <= mem[fin_idx];
         end
         if (state == ST_IDLE) begin
            if (req_ok) begin
               lat_wr   <= Wr;
               lat_idx  <= Addr[DEPTH_LOG2:1];
               lat_data <= DataIn;
               if (LATENCY > 1) begin
                  state <= ST_BUSY;
                  cnt   <= LAT_M1;
                  Stall <= 1'b1;
               end
            end
         end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
               state <= ST_IDLE;
               Stall <= 1'b0;
            end
         end
      end
   end

   // Storage has no reset; gating on rst drops a write caught by reset.
   always_ff @(posedge clk) begin
      if (rst && fin && fin_wr) begin
         mem[fin_idx] <= fin_data;
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized and directed bench for imem_responder
// Runs a LATENCY=2 and a LATENCY=1 instance against a cycle-number reference model.
module tb_imem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [1:0]       rd, wr, done, stall, err;
   logic [1:0][15:0] addr, din, dout;

   imem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst_n), .Rd(rd[0]), .Wr(wr[0]), .Addr(addr[0]), .DataIn(din[0]),
      .DataOut(dout[0]), .Done(done[0]), .Stall(stall[0]), .Err(err[0]));

   imem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst_n), .Rd(rd[1]), .Wr(wr[1]), .Addr(addr[1]), .DataIn(din[1]),
      .DataOut(dout[1]), .Done(done[1]), .Stall(stall[1]), .Err(err[1]));

   int checks = 0;
   int errors = 0;

   int          lat [2] = '{2, 1};
   int          cyc;
   int          done_at [2];
   int          err_at [2];
   logic [15:0] exp_dout [2];
   logic [15:0] mdl_mem [2][256];
   logic        p_wr [2];
   int          p_idx [2];
   logic [15:0] p_data [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         done_at[d]  = -1;
         err_at[d]   = -1;
         exp_dout[d] = 16'h0;
      end
   endtask

   // A request completes in cycle done_at; its effect is visible from that cycle on.
   task automatic check_outputs();
      for (int d = 0; d < 2; d++) begin
         if (cyc == done_at[d]) begin
            if (p_wr[d]) mdl_mem[d][p_idx[d]] = p_data[d];
            else         exp_dout[d] = mdl_mem[d][p_idx[d]];
         end
         chk($sformatf("done%0d", d),  done[d],  (cyc == done_at[d]));
         chk($sformatf("stall%0d", d), stall[d], (done_at[d] > cyc));
         chk($sformatf("err%0d", d),   err[d],   (cyc == err_at[d]));
         chk($sformatf("dout%0d", d),  dout[d],  exp_dout[d]);
      end
   endtask

   task automatic issue(input int d, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] di);
      rd[d]   = r;
      wr[d]   = w;
      addr[d] = a;
      din[d]  = di;
      if (done_at[d] <= cyc) begin
         if ((r ^ w) && !a[0]) begin
            done_at[d] = cyc + lat[d];
            p_wr[d]    = w;
            p_idx[d]   = int'(a[8:1]);
            p_data[d]  = di;
         end else if (r | w) begin
            err_at[d] = cyc + 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic req(input int d, input logic r, input logic w,
                      input logic [15:0] a, input logic [15:0] di);
      issue(d, r, w, a, di);
      issue(1 - d, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) req(0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   int          nxt [2];
   int          op;
   logic [15:0] ra, old;

   initial begin
      rst_n = 1'b0;
      rd = '0; wr = '0; addr = '0; din = '0;
      cyc = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;

      // Preload every word of both instances.
      nxt = '{0, 0};
      while (nxt[0] < 256 || nxt[1] < 256) begin
         for (int d = 0; d < 2; d++) begin
            if (nxt[d] < 256 && done_at[d] <= cyc) begin
               issue(d, 1'b0, 1'b1, 16'(nxt[d] * 2), 16'($urandom));
               nxt[d]++;
            end else begin
               issue(d, 1'b0, 1'b0, 16'h0, 16'h0);
            end
         end
         tick();
      end
      idle(3);

      // Write then read in the write's Done cycle.
      req(0, 1'b0, 1'b1, 16'h0010, 16'hA5C3);
      idle(1);
      chk("tp1_wdone", done[0], 1);
      req(0, 1'b1, 1'b0, 16'h0010, 16'h0);
      chk("tp1_stall", stall[0], 1);
      idle(1);
      chk("tp1_rdone", done[0], 1);
      chk("tp1_dout", dout[0], 16'hA5C3);

      // Misaligned and conflicting requests.
      idle(1);
      req(0, 1'b1, 1'b0, 16'h0011, 16'h0);
      chk("tp2_err", err[0], 1);
      idle(1);
      chk("tp2_err_clr", err[0], 0);
      old = mdl_mem[0][16];
      req(0, 1'b1, 1'b1, 16'h0020, 16'h5555);
      chk("tp2_conf_err", err[0], 1);
      req(0, 1'b1, 1'b0, 16'h0020, 16'h0);
      idle(1);
      chk("tp2_keep", dout[0], old);

      // Aliasing above the index bits.
      req(0, 1'b0, 1'b1, 16'h0202, 16'h1234);
      idle(1);
      req(0, 1'b1, 1'b0, 16'h0002, 16'h0);
      idle(1);
      chk("tp3_alias", dout[0], 16'h1234);

      // Write attempted while busy is ignored.
      req(0, 1'b1, 1'b0, 16'h0010, 16'h0);
      req(0, 1'b0, 1'b1, 16'h0010, 16'hFFFF);
      idle(1);
      req(0, 1'b1, 1'b0, 16'h0010, 16'h0);
      idle(1);
      chk("tp4_ignored", dout[0], 16'hA5C3);

      // Reset during Stall of a write.
      old = mdl_mem[0][24];
      req(0, 1'b0, 1'b1, 16'h0030, 16'hBEEF);
      issue(0, 1'b0, 1'b0, 16'h0, 16'h0);
      issue(1, 1'b0, 1'b0, 16'h0, 16'h0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("tp5_done", done[0], 0);
      chk("tp5_stall", stall[0], 0);
      chk("tp5_dout", dout[0], 16'h0);
      tick();
      rst_n = 1'b1;
      idle(3);
      req(0, 1'b1, 1'b0, 16'h0030, 16'h0);
      idle(1);
      chk("tp5_kept", dout[0], old);

      // Back-to-back reads at LATENCY=1.
      for (int i = 0; i < 8; i++) begin
         req(1, 1'b1, 1'b0, 16'(2 * i), 16'h0);
         chk($sformatf("tp6_stall%0d", i), stall[1], 0);
         chk($sformatf("tp6_done%0d", i), done[1], 1);
         chk($sformatf("tp6_data%0d", i), dout[1], mdl_mem[1][i]);
      end
      idle(2);

      // Random traffic on both instances, including requests while busy.
      for (int n = 0; n < 800; n++) begin
         for (int d = 0; d < 2; d++) begin
            op = int'($urandom_range(0, 11));
            ra = 16'($urandom) & 16'hFFFE;
            if (op < 6)       issue(d, 1'b1, 1'b0, ra, 16'h0);
            else if (op < 8)  issue(d, 1'b0, 1'b1, ra, 16'($urandom));
            else if (op == 8) issue(d, 1'(op & 1), 1'(~op & 1), ra | 16'h1, 16'($urandom));
            else if (op == 9) issue(d, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
            else              issue(d, 1'b0, 1'b0, 16'h0, 16'h0);
         end
         tick();
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
